// File: rtl/alu_operand_sequencer_if.sv
// Handshake bundle between the pad-side byte stream, the sequencer and the ALU.
//   in_data / in_valid / in_ready : byte stream into the sequencer
//   out_a / out_b / out_opc       : assembled ALU command
//   out_valid / out_ready         : command handshake towards the ALU
// The slave modport is the sequencer's view; master is the surrounding system.
interface alu_operand_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OPC_W  = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [OPC_W-1:0]  out_opc;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_opc, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_opc, out_valid
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Assembles three-byte frames (opcode, operand A, operand B) from a byte stream into one
// parallel ALU command, presented on a valid/ready handshake.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          alu_operand_sequencer_if.slave (byte input and command output handshakes)
//   busy         frame partially received or command pending
//   frame_err    one-cycle pulse on a dropped opcode byte or a discarded frame
//   issue_count  number of accepted commands, modulo 256
// Optional feature: define SEQ_TIMEOUT_EN to abandon partial frames after TIMEOUT idle cycles.
module alu_operand_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  alu_operand_sequencer_if.slave        bus,
  output logic                          busy,
  output logic                          frame_err,
  output logic [7:0]                    issue_count
);

  typedef enum logic [1:0] {StIdle, StWaitA, StWaitB, StIssue} state_e;

  localparam logic [3:0] SyncMarker = 4'hA;

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OPC_W-1:0]  opc_q;
  logic              valid_q;
  logic              err_q;
  logic [7:0]        count_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = valid_q && bus.out_ready;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CntW-1:0] idle_cnt_q;
  logic            timeout_hit;
  // Fires on the TIMEOUT-th consecutive cycle without a transfer.
  assign timeout_hit = !in_xfer && (idle_cnt_q == CntW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
      case (state_q)
        StIdle: begin
          if (in_xfer) begin
            if (bus.in_data[DATA_W-1 -: 4] == SyncMarker) begin
              opc_q   <= bus.in_data[OPC_W-1:0];
              state_q <= StWaitA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StWaitA: begin
          if (in_xfer) begin
            a_q     <= bus.in_data;
            state_q <= StWaitB;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        StWaitB: begin
          if (in_xfer) begin
            b_q     <= bus.in_data;
            valid_q <= 1'b1;
            state_q <= StIssue;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        StIssue: begin
          if (out_xfer) begin
            valid_q <= 1'b0;
            count_q <= count_q + 8'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // No bytes accepted while a command is pending or during reset.
  assign bus.in_ready  = (state_q != StIssue) && !rst;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_opc   = opc_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q != StIdle);
  assign frame_err     = err_q;
  assign issue_count   = count_q;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream feeder for the ALU core. Accepts a byte stream from the pad-side input bus and assembles each three-byte frame (opcode, operand A, operand B) into one parallel ALU command. Presents the command on a valid/ready handshake and counts issued commands for status readback.

## Interface

Parameters:
- `DATA_W`, 8: operand width in bits; equals the byte width of the input bus.
- `OPC_W`, 4: opcode width in bits; taken from the low bits of the opcode byte.
- `TIMEOUT`, 255: idle-cycle limit inside a partial frame. Used only when `SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  DATA_W  incoming frame byte.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  sequencer accepts a byte this cycle.
- `out_a`  output  DATA_W  operand A to the ALU.
- `out_b`  output  DATA_W  operand B to the ALU.
- `out_opc`  output  OPC_W  opcode to the ALU.
- `out_valid`  output  1  command valid.
- `out_ready`  input  1  ALU side accepts the command.
- `busy`  output  1  a frame is partially received or a command is pending.
- `frame_err`  output  1  one-cycle pulse on a dropped byte or discarded frame.
- `issue_count`  output  8  number of accepted commands, wrapping modulo 256.

## Operation

- Input transfer: a byte is transferred on a rising edge where `in_valid && in_ready`. Output transfer: a command is transferred where `out_valid && out_ready`.
- FSM states and transitions:
  - IDLE: waits for the opcode byte.
  - WAIT_A: on a transfer, latches `out_a` and moves to WAIT_B.
  - WAIT_B: on a transfer, latches `out_b` and moves to ISSUE.
  - ISSUE: drives `out_valid`=1; on an output transfer, returns to IDLE.
- Opcode byte accepted in IDLE:
  - Upper nibble must be 4'hA (sync marker).
  - Valid marker: latch `in_data[OPC_W-1:0]` into `out_opc` and move to WAIT_A.
  - Any other upper nibble: drop the byte, pulse `frame_err`, stay in IDLE.
- Ready and busy:
  - `in_ready` = (state != ISSUE) && !rst. Combinational; no bytes are accepted while a command is pending.
  - `busy` = (state != IDLE).
- Output stability: `out_a`, `out_b` and `out_opc` are registered and hold stable from entry into ISSUE until the output transfer. They keep their last values afterwards; downstream qualifies them with `out_valid` only.
- `issue_count` increments by 1 on each output transfer; 255 wraps to 0.
- `frame_err` is registered, high for exactly one cycle per event, and never asserted in ISSUE.
- Reset values:
  - state IDLE.
  - `out_a`, `out_b`, `out_opc`, `out_valid`, `frame_err`, `issue_count` = 0.
  - `busy` = 0.
  - `in_ready` = 0 while `rst` is high, 1 on the first cycle after release.
- Reset mid-frame or mid-issue: the partial frame or pending command is discarded, no `frame_err` pulse, and `issue_count` clears.

## Timing

- Third byte (B) transferred at edge N: `out_valid`=1 in the cycle after edge N.
- `out_ready` already high at that point: the command transfers at edge N+1, and IDLE with `in_ready`=1 follows in the next cycle.
- Minimum frame period: 4 cycles (3 input transfers + 1 issue cycle).
- Back-pressure: `out_ready` low holds ISSUE indefinitely; all outputs stay stable.
- Bad opcode byte transferred at edge N: `frame_err`=1 in the cycle after edge N only.
- Simultaneous `rst` and a transfer on either side: reset wins; no latch and no count.

## Configuration

- Macro `SEQ_TIMEOUT_EN`, defined:
  - An idle counter runs in WAIT_A and WAIT_B. It counts cycles without an input transfer and clears on every transfer or state change.
  - When it reaches `TIMEOUT`, the FSM returns to IDLE, pulses `frame_err` for one cycle, and discards the partial frame. `out_*` registers keep their stale values; `out_valid` stays 0.
  - ISSUE never times out.
- Macro not defined: no counter is built, WAIT_A and WAIT_B wait indefinitely, and `TIMEOUT` is ignored.

## Test plan

- Reset, then bytes 0xA3, 0x12, 0x34 back-to-back with `out_ready`=1:
  - `out_opc`=3, `out_a`=0x12, `out_b`=0x34.
  - `out_valid` high for one cycle; `issue_count`=1.
- Byte 0x53 in IDLE: `frame_err` pulses one cycle, state stays IDLE; then frame 0xA1, 0x01, 0x02 issues `out_opc`=1 normally.
- Full frame with `out_ready`=0 for 5 cycles:
  - `out_valid` held high, `in_ready`=0, outputs stable.
  - Raising `out_ready` completes the transfer; `in_ready` returns to 1.
- 256 consecutive valid frames: `issue_count` wraps to 0 after the last transfer.
- Reset asserted after 0xA2, 0x07: `busy`=0, all outputs 0; then a new frame 0xA4, 0x05, 0x06 issues `out_opc`=4, `out_a`=5, `out_b`=6.
- `SEQ_TIMEOUT_EN` with `TIMEOUT`=8: send 0xA2, then hold `in_valid` low.
  - `frame_err` pulses after 8 idle cycles and the FSM is back in IDLE.
  - Without the macro, `busy` stays 1 for 100+ cycles.
